// File: rtl/video_pkg.sv
// Shared video helpers: log2 for sizing, default active-window origin and
// the pixel lane bit-slice position within a packed memory word.
package video_pkg;

    localparam int DEF_COL_START = 30;
    localparam int DEF_ROW_START = 30;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Lane 0 sits in the MSBs so the leftmost pixel is first in the word.
    function automatic int lane_msb(input int k, input int pix_w, input int word_w);
        return word_w - 1 - k * pix_w;
    endfunction

endpackage

// File: rtl/vid_wr_fifo.sv
// Synchronous FIFO with registered head data; DEPTH entries including the head.
// Latency: a push into an empty FIFO is visible at the outputs after the writing edge.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module vid_wr_fifo
    import video_pkg::*;
#(
    parameter int W     = 55,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CW = clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
    logic [CW-1:0] count, count_n;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        rd_ptr_n = pop_ok ? rd_ptr + PW'(1) : rd_ptr;
        count_n  = count;
        case ({push_ok, pop_ok})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // The head register is loaded from the slot that becomes the head; when the
    // FIFO drains to empty and refills in one step that slot is the one being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (count_n != '0)
                dout <= (push_ok && (wr_ptr == rd_ptr_n)) ? din : mem[rd_ptr_n];
        end
    end

endmodule

// File: rtl/vid_pack_zbt.sv
// Packs windowed pixels into ZBT words (lane 0 in MSBs); VID_PACK_TESTPAT_EN swaps in a coordinate pattern.
// Latency: committing pixel accepted at edge E, FIFO entry written at E+1, wr_valid visible after E+1.
// Backpressure: wr_ready stalls the FIFO head; a commit into a full FIFO without a pop is dropped and counted.
module vid_pack_zbt
    import video_pkg::*;
#(
    parameter int PIX_W        = 18,
    parameter int PIX_PER_WORD = 2,
    parameter int WORD_W       = 36,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int ADDR_W       = 19,
    parameter int COL_START    = DEF_COL_START,
    parameter int ROW_START    = DEF_ROW_START,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic [X_W-1:0]    pix_x,
    input  logic [X_W-1:0]    pix_y,
    input  logic              pix_field,
    input  logic              pix_eol,
    input  logic              frame_start,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              overflow,
    output logic [15:0]       drop_count
);
    localparam int LOG2   = clog2(PIX_PER_WORD);
    localparam int WIDX_W = X_W - LOG2;
    localparam logic [X_W-1:0] COL_S     = X_W'(COL_START);
    localparam logic [X_W-1:0] ROW_S     = X_W'(ROW_START);
    localparam logic [X_W-1:0] LANE_MSK  = X_W'(PIX_PER_WORD - 1);

    logic              acc, same, flush, px_commit, pop, drop, fifo_full, fifo_empty;
    logic [X_W-1:0]    xr, lane;
    logic [Y_W-1:0]    yr;
    logic [WIDX_W-1:0] widx;
    logic [ADDR_W-1:0] addr_new;
    logic [PIX_W-1:0]  pix_sel;
    logic [WORD_W-1:0] px_data;

    logic              ow_vld, ow_done, cm_vld;
    logic              ow_vld_n, ow_done_n, cm_vld_n;
    logic [ADDR_W-1:0] ow_addr, ow_addr_n, cm_addr, cm_addr_n;
    logic [WORD_W-1:0] ow_data, ow_data_n, cm_data, cm_data_n;

    assign acc      = pix_valid && (pix_x >= COL_S) && (pix_y >= ROW_S);
    assign xr       = pix_x - COL_S;
    assign yr       = Y_W'(pix_y - ROW_S);
    assign lane     = xr & LANE_MSK;
    assign widx     = WIDX_W'(xr >> LOG2);
    assign addr_new = {yr, pix_field, widx};

`ifdef VID_PACK_TESTPAT_EN
    logic [17:0] tp;
    assign tp      = {xr[5:0], yr[5:0], pix_field, 5'b0};
    assign pix_sel = PIX_W'(tp);
`else
    assign pix_sel = pix_data;
`endif

    // ow_done marks a complete word parked behind a flush that took the commit slot.
    assign same      = ow_vld && !ow_done && !frame_start && (ow_addr == addr_new);
    assign flush     = ow_vld && !frame_start && (ow_done || (acc && !same));
    assign px_commit = acc && ((lane == LANE_MSK) || pix_eol);

    always_comb begin
        px_data = same ? ow_data : '0;
        for (int k = 0; k < PIX_PER_WORD; k++)
            if (lane == X_W'(k)) px_data[lane_msb(k, PIX_W, WORD_W) -: PIX_W] = pix_sel;
    end

    always_comb begin
        ow_vld_n  = ow_vld;
        ow_done_n = ow_done;
        ow_addr_n = ow_addr;
        ow_data_n = ow_data;
        cm_vld_n  = 1'b0;
        cm_addr_n = cm_addr;
        cm_data_n = cm_data;
        if (frame_start) begin
            ow_vld_n  = 1'b0;
            ow_done_n = 1'b0;
        end
        if (flush) begin
            cm_vld_n  = 1'b1;
            cm_addr_n = ow_addr;
            cm_data_n = ow_data;
            ow_vld_n  = 1'b0;
            ow_done_n = 1'b0;
        end
        if (acc) begin
            if (px_commit && !flush) begin
                cm_vld_n  = 1'b1;
                cm_addr_n = addr_new;
                cm_data_n = px_data;
                ow_vld_n  = 1'b0;
                ow_done_n = 1'b0;
            end else begin
                ow_vld_n  = 1'b1;
                ow_done_n = px_commit;
                ow_addr_n = addr_new;
                ow_data_n = px_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ow_vld  <= 1'b0;
            ow_done <= 1'b0;
            ow_addr <= '0;
            ow_data <= '0;
            cm_vld  <= 1'b0;
            cm_addr <= '0;
            cm_data <= '0;
        end else begin
            ow_vld  <= ow_vld_n;
            ow_done <= ow_done_n;
            ow_addr <= ow_addr_n;
            ow_data <= ow_data_n;
            cm_vld  <= cm_vld_n;
            cm_addr <= cm_addr_n;
            cm_data <= cm_data_n;
        end
    end

    assign wr_valid = !fifo_empty;
    assign pop      = wr_valid && wr_ready;
    assign drop     = cm_vld && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (frame_start)
                drop_count <= '0;
            else if (drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

    vid_wr_fifo #(
        .W     (ADDR_W + WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cm_vld),
        .din   ({cm_addr, cm_data}),
        .pop   (pop),
        .dout  ({wr_addr, wr_data}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_vid_pack_zbt.sv
// Directed bench for vid_pack_zbt at default parameters; expected words are hand-built
// from pixel coordinates, and follow the coordinate pattern when VID_PACK_TESTPAT_EN is set.
module tb_vid_pack_zbt;

`ifdef VID_PACK_TESTPAT_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        pix_valid;
    logic [17:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_field;
    logic        pix_eol;
    logic        frame_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [35:0] wr_data;
    logic        overflow;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    vid_pack_zbt dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_field   (pix_field),
        .pix_eol     (pix_eol),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel value as packed: raw data, or the coordinate pattern in test-pattern builds.
    function automatic logic [17:0] ep(input int x, input int y, input logic f, input logic [17:0] d);
        logic [9:0]  xr;
        logic [9:0]  yr;
        logic [17:0] tp;
        xr = 10'(x - 30);
        yr = 10'(y - 30);
        tp = {xr[5:0], yr[5:0], f, 5'b0};
        return TP ? tp : d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic f, input logic e, input logic [17:0] d);
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pix_field = f;
        pix_eol   = e;
        pix_data  = d;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        pix_eol   = 1'b0;
    endtask

    initial begin
        logic [17:0] a, b, p;
        rst = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_x = '0; pix_y = '0;
        pix_field = 1'b0; pix_eol = 1'b0; frame_start = 1'b0; wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(wr_valid), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic pair at window origin: latency and lane order.
        a = 18'h2A5A5; b = 18'h15A5A;
        pix(30, 30, 1'b0, 1'b0, a);
        pix(31, 30, 1'b0, 1'b0, b);
        chk("pair_lat1", 64'(wr_valid), 64'd0);
        @(negedge clk);
        chk("pair_valid", 64'(wr_valid), 64'd1);
        chk("pair_addr", 64'(wr_addr), 64'd0);
        chk("pair_data", 64'(wr_data), 64'({ep(30, 30, 1'b0, a), ep(31, 30, 1'b0, b)}));
        @(negedge clk);
        chk("pair_drain", 64'(wr_valid), 64'd0);

        // Out-of-window pixels, then a lone eol pixel in field 1.
        pix(29, 30, 1'b0, 1'b1, 18'h11111);
        pix(30, 29, 1'b0, 1'b1, 18'h22222);
        repeat (3) @(negedge clk);
        chk("window_none", 64'(wr_valid), 64'd0);
        p = 18'h3C3C3;
        pix(33, 31, 1'b1, 1'b1, p);
        @(negedge clk);
        chk("eol_valid", 64'(wr_valid), 64'd1);
        chk("eol_addr", 64'(wr_addr), 64'd1537);
        chk("eol_data", 64'(wr_data), 64'({18'h0, ep(33, 31, 1'b1, p)}));
        @(negedge clk);

        // Column skip: two words, each with only its own lane filled.
        pix(30, 30, 1'b0, 1'b0, a);
        pix(33, 30, 1'b0, 1'b0, b);
        @(negedge clk);
        chk("skip_w0_addr", 64'(wr_addr), 64'd0);
        chk("skip_w0_data", 64'(wr_data), 64'({ep(30, 30, 1'b0, a), 18'h0}));
        @(negedge clk);
        chk("skip_w1_valid", 64'(wr_valid), 64'd1);
        chk("skip_w1_addr", 64'(wr_addr), 64'd1);
        chk("skip_w1_data", 64'(wr_data), 64'({18'h0, ep(33, 30, 1'b0, b)}));
        @(negedge clk);
        chk("skip_drain", 64'(wr_valid), 64'd0);

        // frame_start discards the open lane-0 pixel.
        pix(30, 60, 1'b0, 1'b0, a);
        frame_start = 1'b1;
        pix(31, 60, 1'b0, 1'b0, b);
        frame_start = 1'b0;
        @(negedge clk);
        chk("fs_addr", 64'(wr_addr), 64'd30720);
        chk("fs_data", 64'(wr_data), 64'({18'h0, ep(31, 60, 1'b0, b)}));
        @(negedge clk);
        chk("fs_drain", 64'(wr_valid), 64'd0);

        // Six full words against a stalled FIFO of four.
        wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pix(30, 30 + i, 1'b0, 1'b0, 18'h10000 + 18'(i));
            pix(31, 30 + i, 1'b0, 1'b0, 18'h20000 + 18'(i));
        end
        repeat (2) @(negedge clk);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(drop_count), 64'd2);
        chk("ovf_valid", 64'(wr_valid), 64'd1);
        chk("ovf_head_addr", 64'(wr_addr), 64'd0);
        chk("ovf_head_data", 64'(wr_data), 64'({ep(30, 30, 1'b0, 18'h10000), ep(31, 30, 1'b0, 18'h20000)}));
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("fs_count_clr", 64'(drop_count), 64'd0);
        chk("fs_ovf_sticky", 64'(overflow), 64'd1);
        chk("fs_head_kept", 64'(wr_addr), 64'd0);
        wr_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("drain_addr", 64'(wr_addr), 64'(k << 10));
            chk("drain_data", 64'(wr_data),
                64'({ep(30, 30 + k, 1'b0, 18'h10000 + 18'(k)), ep(31, 30 + k, 1'b0, 18'h20000 + 18'(k))}));
        end
        @(negedge clk);
        chk("drain_empty", 64'(wr_valid), 64'd0);

        // Reset mid-word with two entries queued.
        wr_ready = 1'b0;
        pix(30, 40, 1'b0, 1'b0, a);
        pix(31, 40, 1'b0, 1'b0, b);
        pix(30, 41, 1'b0, 1'b0, a);
        pix(31, 41, 1'b0, 1'b0, b);
        pix(30, 42, 1'b0, 1'b0, p);
        @(negedge clk);
        chk("pre_rst_addr", 64'(wr_addr), 64'(10 << 10));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(wr_valid), 64'd0);
        chk("mid_rst_addr", 64'(wr_addr), 64'd0);
        chk("mid_rst_data", 64'(wr_data), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wr_ready = 1'b1;
        @(negedge clk);
        pix(30, 50, 1'b0, 1'b0, a);
        pix(31, 50, 1'b0, 1'b0, b);
        @(negedge clk);
        chk("post_rst_valid", 64'(wr_valid), 64'd1);
        chk("post_rst_addr", 64'(wr_addr), 64'(20 << 10));
        chk("post_rst_data", 64'(wr_data), 64'({ep(30, 50, 1'b0, a), ep(31, 50, 1'b0, b)}));
        @(negedge clk);
        chk("post_rst_drain", 64'(wr_valid), 64'd0);

`ifdef VID_PACK_TESTPAT_EN
        pix(31, 32, 1'b0, 1'b1, 18'h3FFFF);
        @(negedge clk);
        chk("tp_data", 64'(wr_data), 64'({18'h0, 6'd1, 6'd2, 1'b0, 5'b0}));
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
